uart_baud_tick_generator: RTL and testbench
===========================================

// Module: uart_baud_tick_generator
// PURPOSE
//  Runtime-programmable UART baud timebase with fractional divider. Produces a one-cycle rx_tick at
//  baud*OVERSAMPLE for RX mid-bit sampling, a one-cycle tx_tick at baud rate, and a baud-rate square wave.
//  Sits between the system clock and the UART TX/RX engines; divisor is reloadable glitch-free at runtime.
// PARAMETERS
//  SYSTM_OPERN_FREQ   11059200  system clock frequency, Hz
//  DEFAULT_BAUD_RATE  9600      baud rate used for reset divisor
//  OVERSAMPLE         16        rx_ticks per bit; even, >=4
//  DIV_WIDTH          16        width of integer divisor
//  FRAC_WIDTH         4         width of fractional divisor (units of 1/2^FRAC_WIDTH clock)
// PORTS
//  systm_clock_in   in   1           system clock, all logic on rising edge
//  systm_reset_in   in   1           synchronous, active-high reset
//  baud_enable_in   in   1           1 = run; 0 = hold in idle
//  div_int_in       in   DIV_WIDTH   integer clocks per rx_tick
//  div_frac_in      in   FRAC_WIDTH  fractional clocks per rx_tick
//  div_load_in      in   1           1-cycle strobe: capture div_int_in/div_frac_in
//  div_pending_out  out  1           captured divisor not yet applied
//  rx_tick_out      out  1           1-cycle pulse, rate baud*OVERSAMPLE
//  tx_tick_out      out  1           1-cycle pulse, rate baud
//  baud_clock_out   out  1           square wave at baud rate
// BEHAVIOUR
//  - Reset: rx_tick_out=tx_tick_out=baud_clock_out=div_pending_out=0; active divisor = DEFAULT_DIV_INT/
//    DEFAULT_DIV_FRAC (from package; 72/0 at defaults); down-counter = DEFAULT_DIV_INT-1; frac_acc=0; os_ctr=0.
//  - Period expiry: counter==0 and enabled -> rx_tick_out=1 that cycle; {carry,frac_acc} <= frac_acc+div_frac;
//    counter <= div_int-1+carry. Period lengths are div_int or div_int+1; mean = div_int+div_frac/2^FRAC_WIDTH.
//  - Otherwise counter decrements by 1. All outputs registered-equivalent; no combinational path from inputs.
//  - First rx_tick_out occurs div_int clocks after reset deasserts (enable high).
//  - os_ctr increments on each rx_tick, wraps OVERSAMPLE-1 -> 0; tx_tick_out=1 on the rx_tick with os_ctr==OVERSAMPLE-1.
//  - baud_clock_out = 1 while os_ctr >= OVERSAMPLE/2, else 0 (falling edge coincides with tx_tick).
//  - Divisor clamp: div_int 0 treated as 1. div_int=1, frac=0 -> rx_tick_out every cycle.
//  - div_load_in: values captured into pending regs, div_pending_out=1 next cycle; applied at next expiry
//    (expiry reload uses new divisor); div_pending_out clears same cycle as apply. frac_acc not cleared.
//  - div_load_in coincident with expiry: new divisor used for that reload directly; div_pending_out stays 0.
//  - div_load_in while pending: pending values overwritten, last load wins.
//  - baud_enable_in=0: ticks 0, baud_clock_out 0, os_ctr=0, frac_acc=0, counter held at div_int-1;
//    pending divisor applied immediately. Re-enable: first rx_tick after exactly div_int clocks.
//  - Reset mid-period or mid-pending: dominates all inputs; pending load discarded.
// STRUCTURE
//  - Shared package uart_pkg: function calc_div(freq, baud, os) returning integer/fractional parts
//    (fraction rounded to nearest), constants DEFAULT_DIV_INT, DEFAULT_DIV_FRAC.
//  - Sub-module uart_frac_divider: down-counter + fractional accumulator + pending-divisor regs, emits rx_tick.
//    Top wraps it with os_ctr, tx_tick and baud_clock_out generation.
// TESTING
//  - Reset, defaults, enable=1 -> rx_tick every 72 clks, tx_tick every 1152 clks, baud_clock_out 50% duty.
//  - Load div_int=10, div_frac=8 -> rx_tick periods 10,11,10,11...; 32 ticks in exactly 336 clks.
//  - Load div_int=20 mid-period of div 72 -> pending=1 until current 72-clk period ends, next period 20 clks.
//  - div_load coincident with expiry, div_int=5 -> next period 5 clks, div_pending_out never 1.
//  - div_int=0 and div_int=1, frac=0 -> rx_tick high every cycle, tx_tick every 16 cycles.
//  - Enable low 100 clks mid-bit, then high -> no ticks while low, first rx_tick div_int clks after; reset
//    asserted mid-period -> all outputs 0 next cycle, first tick 72 clks after release.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared UART timebase definitions. Holds the divisor-pair type,
//             the calc_div() helper that turns clock/baud/oversample figures
//             into integer + fractional clocks-per-rx_tick, and the default
//             divisor constants for the standard 11.0592 MHz / 9600 baud /
//             x16 setup.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef struct packed {
        logic [31:0] int_part;   // whole clocks per rx_tick
        logic [31:0] frac_part;  // extra clocks in units of 1/2^frac_w
    } div_pair_t;

    // Clocks per rx_tick = freq / (baud * os), expressed in 1/2^frac_w units
    // and rounded to nearest before being split into integer/fraction.
    function automatic div_pair_t calc_div(
        input longint freq,
        input longint baud,
        input longint os,
        input int     frac_w
    );
        longint    num;
        longint    den;
        longint    q;
        div_pair_t res;
        num           = freq << frac_w;
        den           = baud * os;
        q             = (num + (den / 2)) / den;
        res.int_part  = 32'(q >> frac_w);
        res.frac_part = 32'(q & ((64'sd1 << frac_w) - 64'sd1));
        return res;
    endfunction

    localparam div_pair_t DEFAULT_DIV      = calc_div(64'd11059200, 64'd9600, 64'd16, 4);
    localparam int        DEFAULT_DIV_INT  = int'(DEFAULT_DIV.int_part);
    localparam int        DEFAULT_DIV_FRAC = int'(DEFAULT_DIV.frac_part);

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_frac_divider.sv
`default_nettype none
// ============================================================================
//  Module   : uart_frac_divider
//  Purpose  : Fractional clock divider producing a one-cycle rx_tick. A
//             down-counter times each period; a fractional accumulator adds
//             one extra clock whenever it overflows so the mean period is
//             div_int + div_frac/2^FRAC_WIDTH. New divisors are staged in
//             pending registers and take effect at the next period boundary.
//  Ports    : systm_clock_in  - system clock
//             systm_reset_in  - synchronous active-high reset
//             baud_enable_in  - 1 = run, 0 = idle (counter parked)
//             div_int_in      - integer clocks per rx_tick
//             div_frac_in     - fractional clocks per rx_tick
//             div_load_in     - strobe capturing div_int_in/div_frac_in
//             div_pending_out - staged divisor not yet applied
//             rx_tick_out     - registered one-cycle period-expiry pulse
//  Revision : 1.0 - initial release
// ============================================================================
module uart_frac_divider
    import uart_pkg::*;
#(
    parameter int          DIV_WIDTH    = 16,
    parameter int          FRAC_WIDTH   = 4,
    parameter int unsigned RST_DIV_INT  = 72,
    parameter int unsigned RST_DIV_FRAC = 0
) (
    input  logic                  systm_clock_in,
    input  logic                  systm_reset_in,
    input  logic                  baud_enable_in,
    input  logic [DIV_WIDTH-1:0]  div_int_in,
    input  logic [FRAC_WIDTH-1:0] div_frac_in,
    input  logic                  div_load_in,
    output logic                  div_pending_out,
    output logic                  rx_tick_out
);

    localparam logic [DIV_WIDTH-1:0]  c_RST_INT  = DIV_WIDTH'(RST_DIV_INT);
    localparam logic [FRAC_WIDTH-1:0] c_RST_FRAC = FRAC_WIDTH'(RST_DIV_FRAC);
    localparam logic [DIV_WIDTH-1:0]  c_RST_EFF  = (c_RST_INT == '0) ? DIV_WIDTH'(1) : c_RST_INT;
    localparam logic [DIV_WIDTH-1:0]  c_ONE      = DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0]  r_div_int;
    logic [FRAC_WIDTH-1:0] r_div_frac;
    logic [DIV_WIDTH-1:0]  r_pend_int;
    logic [FRAC_WIDTH-1:0] r_pend_frac;
    logic                  r_pending;
    logic [DIV_WIDTH-1:0]  r_count;
    logic [FRAC_WIDTH-1:0] r_frac_acc;
    logic                  r_rx_tick;

    logic [DIV_WIDTH-1:0]  w_nxt_int;
    logic [FRAC_WIDTH-1:0] w_nxt_frac;
    logic [DIV_WIDTH-1:0]  w_eff_int;
    logic [FRAC_WIDTH-1:0] w_acc_sum;
    logic                  w_carry;
    logic                  w_expire;
    logic [DIV_WIDTH-1:0]  w_reload;

    // Divisor that applies at the next reload point: a same-cycle load wins,
    // then any staged value, otherwise the active divisor carries on.
    always_comb begin
        w_nxt_int  = r_div_int;
        w_nxt_frac = r_div_frac;
        if (div_load_in) begin
            w_nxt_int  = div_int_in;
            w_nxt_frac = div_frac_in;
        end else if (r_pending) begin
            w_nxt_int  = r_pend_int;
            w_nxt_frac = r_pend_frac;
        end
        // A zero divisor would never expire; run it as divide-by-one.
        w_eff_int              = (w_nxt_int == '0) ? c_ONE : w_nxt_int;
        {w_carry, w_acc_sum}   = {1'b0, r_frac_acc} + {1'b0, w_nxt_frac};
        w_expire               = baud_enable_in && (r_count == '0);
        w_reload               = w_eff_int - c_ONE + DIV_WIDTH'(w_carry);
    end

    always_ff @(posedge systm_clock_in) begin
        if (systm_reset_in) begin
            r_div_int   <= c_RST_INT;
            r_div_frac  <= c_RST_FRAC;
            r_pend_int  <= '0;
            r_pend_frac <= '0;
            r_pending   <= 1'b0;
            r_count     <= c_RST_EFF - c_ONE;
            r_frac_acc  <= '0;
            r_rx_tick   <= 1'b0;
        end else if (!baud_enable_in) begin
            // Idle: adopt any new divisor at once and park the counter so
            // the first tick after re-enable is a full period away.
            r_div_int  <= w_nxt_int;
            r_div_frac <= w_nxt_frac;
            r_pending  <= 1'b0;
            r_count    <= w_eff_int - c_ONE;
            r_frac_acc <= '0;
            r_rx_tick  <= 1'b0;
        end else if (w_expire) begin
            r_div_int  <= w_nxt_int;
            r_div_frac <= w_nxt_frac;
            r_pending  <= 1'b0;
            r_count    <= w_reload;
            r_frac_acc <= w_acc_sum;
            r_rx_tick  <= 1'b1;
        end else begin
            r_count   <= r_count - c_ONE;
            r_rx_tick <= 1'b0;
            if (div_load_in) begin
                r_pend_int  <= div_int_in;
                r_pend_frac <= div_frac_in;
                r_pending   <= 1'b1;
            end
        end
    end

    assign div_pending_out = r_pending;
    assign rx_tick_out     = r_rx_tick;

endmodule : uart_frac_divider
`default_nettype wire

// File: rtl/uart_baud_tick_generator.sv
`default_nettype none
// ============================================================================
//  Module   : uart_baud_tick_generator
//  Purpose  : Runtime-programmable UART baud timebase. Wraps the fractional
//             divider (rx_tick at baud*OVERSAMPLE) with an oversample counter
//             that derives the bit-rate tx_tick and a baud-rate square wave.
//  Ports    : systm_clock_in  - system clock, rising edge
//             systm_reset_in  - synchronous active-high reset
//             baud_enable_in  - 1 = run, 0 = hold idle
//             div_int_in      - integer clocks per rx_tick
//             div_frac_in     - fractional clocks per rx_tick
//             div_load_in     - strobe capturing the divisor inputs
//             div_pending_out - captured divisor not yet applied
//             rx_tick_out     - one-cycle pulse at baud*OVERSAMPLE
//             tx_tick_out     - one-cycle pulse at baud rate
//             baud_clock_out  - square wave at baud rate
//  Revision : 1.0 - initial release
// ============================================================================
module uart_baud_tick_generator
    import uart_pkg::*;
#(
    parameter int SYSTM_OPERN_FREQ  = 11059200,
    parameter int DEFAULT_BAUD_RATE = 9600,
    parameter int OVERSAMPLE        = 16,
    parameter int DIV_WIDTH         = 16,
    parameter int FRAC_WIDTH        = 4
) (
    input  logic                  systm_clock_in,
    input  logic                  systm_reset_in,
    input  logic                  baud_enable_in,
    input  logic [DIV_WIDTH-1:0]  div_int_in,
    input  logic [FRAC_WIDTH-1:0] div_frac_in,
    input  logic                  div_load_in,
    output logic                  div_pending_out,
    output logic                  rx_tick_out,
    output logic                  tx_tick_out,
    output logic                  baud_clock_out
);

    localparam div_pair_t        c_RST_DIV = calc_div(longint'(SYSTM_OPERN_FREQ),
                                                      longint'(DEFAULT_BAUD_RATE),
                                                      longint'(OVERSAMPLE), FRAC_WIDTH);
    localparam int               c_OS_W    = $clog2(OVERSAMPLE);
    localparam logic [c_OS_W-1:0] c_OS_LAST = c_OS_W'(OVERSAMPLE - 1);
    localparam logic [c_OS_W-1:0] c_OS_HALF = c_OS_W'(OVERSAMPLE / 2);

    logic              w_rx_tick;
    logic [c_OS_W-1:0] r_os_ctr;

    uart_frac_divider #(
        .DIV_WIDTH    (DIV_WIDTH),
        .FRAC_WIDTH   (FRAC_WIDTH),
        .RST_DIV_INT  (int'(c_RST_DIV.int_part)),
        .RST_DIV_FRAC (int'(c_RST_DIV.frac_part))
    ) u_frac_divider (
        .systm_clock_in  (systm_clock_in),
        .systm_reset_in  (systm_reset_in),
        .baud_enable_in  (baud_enable_in),
        .div_int_in      (div_int_in),
        .div_frac_in     (div_frac_in),
        .div_load_in     (div_load_in),
        .div_pending_out (div_pending_out),
        .rx_tick_out     (w_rx_tick)
    );

    // Oversample position within the current bit; advances on every rx_tick.
    always_ff @(posedge systm_clock_in) begin
        if (systm_reset_in || !baud_enable_in) begin
            r_os_ctr <= '0;
        end else if (w_rx_tick) begin
            r_os_ctr <= (r_os_ctr == c_OS_LAST) ? '0 : r_os_ctr + c_OS_W'(1);
        end
    end

    // Both outputs decode registered state only. The bit boundary is the
    // rx_tick seen with the counter at its last position; the square wave is
    // high for the second half of the bit and falls as the counter wraps.
    assign rx_tick_out    = w_rx_tick;
    assign tx_tick_out    = w_rx_tick && (r_os_ctr == c_OS_LAST);
    assign baud_clock_out = (r_os_ctr >= c_OS_HALF);

endmodule : uart_baud_tick_generator
`default_nettype wire

// File: tb/tb_uart_baud_tick_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_baud_tick_generator
//  Purpose  : Directed self-checking bench for uart_baud_tick_generator at
//             default parameters (72 clocks per rx_tick, x16 oversample).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_baud_tick_generator;

    logic        systm_clock_in = 1'b0;
    logic        systm_reset_in;
    logic        baud_enable_in;
    logic [15:0] div_int_in;
    logic [3:0]  div_frac_in;
    logic        div_load_in;
    logic        div_pending_out;
    logic        rx_tick_out;
    logic        tx_tick_out;
    logic        baud_clock_out;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 systm_clock_in = ~systm_clock_in;

    uart_baud_tick_generator dut (
        .systm_clock_in  (systm_clock_in),
        .systm_reset_in  (systm_reset_in),
        .baud_enable_in  (baud_enable_in),
        .div_int_in      (div_int_in),
        .div_frac_in     (div_frac_in),
        .div_load_in     (div_load_in),
        .div_pending_out (div_pending_out),
        .rx_tick_out     (rx_tick_out),
        .tx_tick_out     (tx_tick_out),
        .baud_clock_out  (baud_clock_out)
    );

    // One clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge systm_clock_in);
        #1;
    endtask

    // Clocks until the next rx_tick, or -1 if none within limit.
    task automatic wait_rx(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (rx_tick_out) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        systm_reset_in = 1'b1;
        baud_enable_in = 1'b1;
        div_load_in    = 1'b0;
        div_int_in     = '0;
        div_frac_in    = '0;
        repeat (3) step();
        tests_run++;
        if ({rx_tick_out, tx_tick_out, baud_clock_out, div_pending_out} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected 0000",
                     {rx_tick_out, tx_tick_out, baud_clock_out, div_pending_out});
        end
        systm_reset_in = 1'b0;
        wait_rx(200, n);
        tests_run++;
        if (n !== 72) begin
            tests_failed++;
            $display("FAIL reset_first_tick: got %0d clocks expected 72", n);
        end
    endtask

    task automatic test_defaults();
        int n;
        int hi;
        int tx_at;
        bit found;
        for (int k = 0; k < 3; k++) begin
            wait_rx(200, n);
            tests_run++;
            if (n !== 72) begin
                tests_failed++;
                $display("FAIL default_rx_period[%0d]: got %0d expected 72", k, n);
            end
        end
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (tx_tick_out) begin
                found = 1'b1;
                break;
            end
        end
        tests_run++;
        if (found !== 1'b1) begin
            tests_failed++;
            $display("FAIL default_tx_seen: got %0d expected 1", found);
        end
        tests_run++;
        if (rx_tick_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL tx_with_rx: rx_tick got %b expected 1", rx_tick_out);
        end
        hi    = 0;
        tx_at = -1;
        for (int i = 1; i <= 1152; i++) begin
            step();
            if (baud_clock_out) hi++;
            if (tx_tick_out && tx_at < 0) tx_at = i;
        end
        tests_run++;
        if (tx_at !== 1152) begin
            tests_failed++;
            $display("FAIL default_tx_period: got %0d expected 1152", tx_at);
        end
        tests_run++;
        if (hi !== 576) begin
            tests_failed++;
            $display("FAIL baud_duty: high clocks got %0d expected 576", hi);
        end
    endtask

    task automatic test_frac();
        int n;
        int c;
        int total;
        bit pend_bad;
        int exp_per[4] = '{10, 11, 10, 11};
        int per[4];
        wait_rx(200, n);               // aligned on a tick, c = 0
        div_int_in  = 16'd10;
        div_frac_in = 4'd8;
        div_load_in = 1'b1;
        step();                         // c = 1
        div_load_in = 1'b0;
        c        = 1;
        pend_bad = 1'b0;
        tests_run++;
        if (div_pending_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL frac_pending_set: got %b expected 1", div_pending_out);
        end
        while (!rx_tick_out && c < 200) begin
            step();
            c++;
            if (!rx_tick_out && div_pending_out !== 1'b1) pend_bad = 1'b1;
        end
        tests_run++;
        if (c !== 72 || pend_bad || div_pending_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL frac_apply: period got %0d pend_bad %0d pend %b expected 72 0 0",
                     c, pend_bad, div_pending_out);
        end
        total = 0;
        for (int k = 0; k < 32; k++) begin
            wait_rx(30, n);
            if (k < 4) per[k] = n;
            total += n;
        end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (per[k] !== exp_per[k]) begin
                tests_failed++;
                $display("FAIL frac_period[%0d]: got %0d expected %0d", k, per[k], exp_per[k]);
            end
        end
        tests_run++;
        if (total !== 336) begin
            tests_failed++;
            $display("FAIL frac_32_ticks: got %0d clocks expected 336", total);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        repeat (4) step();
        div_int_in  = 16'd30;
        div_frac_in = 4'd0;
        div_load_in = 1'b1;
        step();
        div_load_in = 1'b0;
        tests_run++;
        if (div_pending_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_pending_set: got %b expected 1", div_pending_out);
        end
        systm_reset_in = 1'b1;
        step();
        tests_run++;
        if ({rx_tick_out, tx_tick_out, baud_clock_out, div_pending_out} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got %b expected 0000",
                     {rx_tick_out, tx_tick_out, baud_clock_out, div_pending_out});
        end
        systm_reset_in = 1'b0;
        wait_rx(200, n);
        tests_run++;
        if (n !== 72) begin
            tests_failed++;
            $display("FAIL midreset_first_tick: got %0d expected 72", n);
        end
        wait_rx(200, n);
        tests_run++;
        if (n !== 72) begin
            tests_failed++;
            $display("FAIL midreset_load_discarded: period got %0d expected 72", n);
        end
    endtask

    task automatic test_pending();
        int n;
        int c;
        bit pend_bad;
        repeat (30) step();             // c = 30 into a 72-clock period
        div_int_in  = 16'd20;
        div_frac_in = 4'd0;
        div_load_in = 1'b1;
        step();                         // c = 31
        div_load_in = 1'b0;
        c        = 31;
        pend_bad = 1'b0;
        tests_run++;
        if (div_pending_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL pend20_set: got %b expected 1", div_pending_out);
        end
        while (!rx_tick_out && c < 200) begin
            step();
            c++;
            if (!rx_tick_out && div_pending_out !== 1'b1) pend_bad = 1'b1;
        end
        tests_run++;
        if (c !== 72 || pend_bad) begin
            tests_failed++;
            $display("FAIL pend20_old_period: got %0d pend_bad %0d expected 72 0", c, pend_bad);
        end
        tests_run++;
        if (div_pending_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL pend20_clear: got %b expected 0", div_pending_out);
        end
        wait_rx(100, n);
        tests_run++;
        if (n !== 20) begin
            tests_failed++;
            $display("FAIL pend20_new_period: got %0d expected 20", n);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        bit pend_seen;
        repeat (19) step();             // counter now at 0
        div_int_in  = 16'd5;
        div_frac_in = 4'd0;
        div_load_in = 1'b1;
        step();                         // expiry edge with load
        div_load_in = 1'b0;
        tests_run++;
        if (rx_tick_out !== 1'b1 || div_pending_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_expiry: rx %b pend %b expected 1 0", rx_tick_out, div_pending_out);
        end
        for (int k = 0; k < 2; k++) begin
            c         = 0;
            pend_seen = 1'b0;
            do begin
                step();
                c++;
                if (div_pending_out) pend_seen = 1'b1;
            end while (!rx_tick_out && c < 50);
            tests_run++;
            if (c !== 5 || pend_seen) begin
                tests_failed++;
                $display("FAIL b2b_period[%0d]: got %0d pend_seen %0d expected 5 0", k, c, pend_seen);
            end
        end
    endtask

    task automatic test_div_small();
        int rx_cnt;
        int tx_cnt;
        bit found;
        logic [15:0] divs[2] = '{16'd0, 16'd1};
        for (int d = 0; d < 2; d++) begin
            div_int_in  = divs[d];
            div_frac_in = 4'd0;
            div_load_in = 1'b1;
            step();
            div_load_in = 1'b0;
            repeat (8) step();
            found = 1'b0;
            for (int i = 0; i < 40; i++) begin
                step();
                if (tx_tick_out) begin
                    found = 1'b1;
                    break;
                end
            end
            rx_cnt = 0;
            tx_cnt = 0;
            for (int i = 0; i < 32; i++) begin
                step();
                if (rx_tick_out) rx_cnt++;
                if (tx_tick_out) tx_cnt++;
            end
            tests_run++;
            if (found !== 1'b1) begin
                tests_failed++;
                $display("FAIL div%0d_tx_seen: got %0d expected 1", divs[d], found);
            end
            tests_run++;
            if (rx_cnt !== 32) begin
                tests_failed++;
                $display("FAIL div%0d_rx_every_cycle: got %0d expected 32", divs[d], rx_cnt);
            end
            tests_run++;
            if (tx_cnt !== 2 || tx_tick_out !== 1'b1) begin
                tests_failed++;
                $display("FAIL div%0d_tx_every_16: count %0d last %b expected 2 1",
                         divs[d], tx_cnt, tx_tick_out);
            end
        end
    endtask

    task automatic test_enable();
        int n;
        bit tick_seen;
        repeat (7) step();
        baud_enable_in = 1'b0;
        tick_seen      = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i == 50) begin
                div_int_in  = 16'd12;
                div_frac_in = 4'd0;
                div_load_in = 1'b1;
            end
            step();
            div_load_in = 1'b0;
            if (rx_tick_out || tx_tick_out || baud_clock_out) tick_seen = 1'b1;
        end
        tests_run++;
        if (tick_seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL disabled_quiet: activity got %0d expected 0", tick_seen);
        end
        tests_run++;
        if (div_pending_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL disabled_load_applied: pending got %b expected 0", div_pending_out);
        end
        baud_enable_in = 1'b1;
        wait_rx(100, n);
        tests_run++;
        if (n !== 12) begin
            tests_failed++;
            $display("FAIL reenable_first_tick: got %0d expected 12", n);
        end
        wait_rx(100, n);
        tests_run++;
        if (n !== 12) begin
            tests_failed++;
            $display("FAIL reenable_period: got %0d expected 12", n);
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_frac();
        test_reset_mid();
        test_pending();
        test_back_to_back();
        test_div_small();
        test_enable();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_uart_baud_tick_generator
`default_nettype wire
